// File: rtl/spi_word_tx_if.sv
// Host-side bundle for spi_word_tx: the frame request, the four words,
// status, and the three SPI wires. The driver of the frame request uses
// the master modport, and the transmitter itself uses the slave modport.
interface spi_word_tx_if;
  logic        i_start;
  logic [15:0] i_data0;
  logic [15:0] i_data1;
  logic [15:0] i_data2;
  logic [15:0] i_data3;
  logic        o_busy;
  logic        o_done;
  logic        o_SPI_CS;
  logic        o_SPI_clock;
  logic        o_SPI_data;

  modport master (
    output i_start, i_data0, i_data1, i_data2, i_data3,
    input  o_busy, o_done, o_SPI_CS, o_SPI_clock, o_SPI_data
  );

  modport slave (
    input  i_start, i_data0, i_data1, i_data2, i_data3,
    output o_busy, o_done, o_SPI_CS, o_SPI_clock, o_SPI_data
  );
endinterface

// File: rtl/spi_word_tx.sv
// spi_word_tx: SPI mode-0 master that sends one frame of four 16-bit words,
// MSB first. Clock and chip select are paced slowly (HALF_PERIOD system
// clocks per SPI half-period) so that a slave with a 3-sample deglitch filter
// sees every edge. All outputs come straight from flops.
module spi_word_tx #(
  parameter int HALF_PERIOD = 8,
  parameter int GAP_CYCLES  = 16
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  spi_word_tx_if.slave  bus
);

  // One counter serves the half-period, hold and gap intervals, so it is
  // sized for the longer of the two.
  localparam int MAX_COUNT = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
  localparam int CW        = $clog2(MAX_COUNT);

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SHIFT_LO = 3'd1;
  localparam logic [2:0] SHIFT_HI = 3'd2;
  localparam logic [2:0] HOLD     = 3'd3;
  localparam logic [2:0] GAP      = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] half_cnt;
  logic [5:0]    bit_cnt;
  // The first bit (i_data0[15]) goes straight onto the data line when the
  // frame is accepted, so only the remaining 63 bits need to be held here.
  logic [62:0]   shreg;
  logic          cs;
  logic          sclk;
  logic          sdata;
  logic          busy;
  logic          done;

  // Frame sequencer: walks low/high SPI half-periods for 64 bits, then
  // holds CS low one more half-period and keeps CS high for the gap.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      cs       <= 1'b1;
      sclk     <= 1'b0;
      sdata    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            shreg    <= {bus.i_data0[14:0], bus.i_data1, bus.i_data2, bus.i_data3};
            sdata    <= bus.i_data0[15];
            cs       <= 1'b0;
            busy     <= 1'b1;
            half_cnt <= '0;
            bit_cnt  <= '0;
            state    <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            sclk     <= 1'b1;
            state    <= SHIFT_HI;
          end else begin
            half_cnt <= half_cnt + CNT_ONE;
          end
        end
        SHIFT_HI: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            sclk     <= 1'b0;
            if (bit_cnt != 6'd63) begin
              sdata   <= shreg[62];
              shreg   <= {shreg[61:0], 1'b0};
              bit_cnt <= bit_cnt + 6'd1;
              state   <= SHIFT_LO;
            end else begin
              sdata <= 1'b0;
              state <= HOLD;
            end
          end else begin
            half_cnt <= half_cnt + CNT_ONE;
          end
        end
        HOLD: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            cs       <= 1'b1;
            state    <= GAP;
          end else begin
            half_cnt <= half_cnt + CNT_ONE;
          end
        end
        GAP: begin
          if (half_cnt == GAP_LAST) begin
            half_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end else begin
            half_cnt <= half_cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_SPI_CS    = cs;
  assign bus.o_SPI_clock = sclk;
  assign bus.o_SPI_data  = sdata;
  assign bus.o_busy      = busy;
  assign bus.o_done      = done;

endmodule

// File: tb/tb_spi_word_tx.sv
// Bench for spi_word_tx. Stimulus pushes the expected 64-bit frame into a
// queue whenever it issues a start the DUT should accept; an independent
// monitor decodes the SPI lines like a slave and pops/compares on every
// CS rise. A second instance with minimum timing drives a deglitching
// receiver model.
module tb_spi_word_tx;

  localparam int HP       = 8;
  localparam int GAP      = 16;
  localparam int CS_LOW   = 129 * HP;
  localparam int DONE_LAT = 129 * HP + GAP;
  localparam int PERIOD   = DONE_LAT + 1;

  logic clock = 1'b0;
  logic rst_n;
  always #5 clock = ~clock;

  spi_word_tx_if bus ();
  spi_word_tx_if lb ();

  spi_word_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
    .i_clock   (clock),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  spi_word_tx #(.HALF_PERIOD(4), .GAP_CYCLES(4)) dut_lb (
    .i_clock   (clock),
    .i_reset_n (rst_n),
    .bus       (lb)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [63:0] exp_q[$];
  int exp_done  = 0;
  int done_count = 0;
  int abort_req  = 0;
  int abort_seen = 0;
  int glitches   = 0;
  bit b2b        = 0;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Cycle counter used to time everything the monitor measures
  always @(posedge clock) cyc <= cyc + 1;

  // Slave-side monitor and scoreboard for the main instance
  logic        prev_cs = 1'b1, prev_sclk = 1'b0, prev_data = 1'b0, prev_done = 1'b0;
  logic [63:0] rx_bits = '0;
  logic [63:0] exp_frame;
  int nbits = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, first_rise = 0, last_fall = 0;
  int bad_data = 0;
  bit rise_in_b2b = 0, done_pending = 0;

  always @(negedge clock) begin
    if (done_pending) begin
      check_output("done_width", {63'd0, bus.o_done}, 64'd0);
      done_pending = 0;
    end
    if (!bus.o_SPI_CS && prev_cs) begin
      if (b2b && rise_in_b2b)
        check_output("cs_high_between_frames", cyc - cs_rise_cyc, GAP + 1);
      cs_fall_cyc = cyc;
      nbits = 0;
      rx_bits = '0;
      bad_data = 0;
    end
    if (bus.o_SPI_clock && !prev_sclk) begin
      if (bus.o_SPI_CS) glitches++;
      else begin
        rx_bits = {rx_bits[62:0], bus.o_SPI_data};
        nbits++;
        if (nbits == 1) first_rise = cyc;
      end
    end
    if (!bus.o_SPI_clock && prev_sclk) last_fall = cyc;
    if (!bus.o_SPI_CS && prev_sclk && bus.o_SPI_clock && (bus.o_SPI_data !== prev_data))
      bad_data++;
    if (bus.o_SPI_CS && !prev_cs) begin
      cs_rise_cyc = cyc;
      rise_in_b2b = b2b;
      if (abort_req > abort_seen) begin
        abort_seen++;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
        check_output("unexpected_frame", 64'd1, 64'd0);
      end else begin
        exp_frame = exp_q.pop_front();
        check_output("rising_edges", nbits, 64);
        check_output("word0", rx_bits[63:48], exp_frame[63:48]);
        check_output("word1", rx_bits[47:32], exp_frame[47:32]);
        check_output("word2", rx_bits[31:16], exp_frame[31:16]);
        check_output("word3", rx_bits[15:0],  exp_frame[15:0]);
        check_output("cs_low_cycles", cs_rise_cyc - cs_fall_cyc, CS_LOW);
        check_output("cs_fall_to_first_rise", first_rise - cs_fall_cyc, HP);
        check_output("last_fall_to_cs_rise", cs_rise_cyc - last_fall, HP);
        check_output("data_change_while_sclk_high", bad_data, 0);
      end
    end
    if (bus.o_done && !prev_done) begin
      done_count++;
      done_pending = 1;
      check_output("done_latency", cyc - cs_fall_cyc, DONE_LAT);
      check_output("busy_at_done", {63'd0, bus.o_busy}, 64'd0);
    end
    prev_cs   = bus.o_SPI_CS;
    prev_sclk = bus.o_SPI_clock;
    prev_data = bus.o_SPI_data;
    prev_done = bus.o_done;
  end

  // Behavioural slave for the loopback instance: 3-sample deglitch on every line
  logic [2:0]  cs_s, sck_s, dat_s;
  logic        cs_f, sck_f, dat_f, cs_f_d, sck_f_d;
  logic [63:0] lb_sh, lb_words;
  logic [6:0]  lb_cnt;
  logic        lb_flag;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cs_s <= 3'b111; sck_s <= 3'b000; dat_s <= 3'b000;
      cs_f <= 1'b1; sck_f <= 1'b0; dat_f <= 1'b0; cs_f_d <= 1'b1; sck_f_d <= 1'b0;
      lb_sh <= '0; lb_words <= '0; lb_cnt <= '0; lb_flag <= 1'b0;
    end else begin
      cs_s  <= {cs_s[1:0], lb.o_SPI_CS};
      sck_s <= {sck_s[1:0], lb.o_SPI_clock};
      dat_s <= {dat_s[1:0], lb.o_SPI_data};
      if (&cs_s) cs_f <= 1'b1; else if (~|cs_s) cs_f <= 1'b0;
      if (&sck_s) sck_f <= 1'b1; else if (~|sck_s) sck_f <= 1'b0;
      if (&dat_s) dat_f <= 1'b1; else if (~|dat_s) dat_f <= 1'b0;
      cs_f_d  <= cs_f;
      sck_f_d <= sck_f;
      if (!cs_f && cs_f_d) lb_cnt <= '0;
      else if (sck_f && !sck_f_d && !cs_f) begin
        lb_sh  <= {lb_sh[62:0], dat_f};
        lb_cnt <= lb_cnt + 7'd1;
      end
      if (cs_f && !cs_f_d && lb_cnt == 7'd64) begin
        lb_words <= lb_sh;
        lb_flag  <= 1'b1;
      end
    end
  end

  // Issues one start pulse and records the frame the DUT must send
  task automatic apply_stimulus(input logic [15:0] d0, input logic [15:0] d1,
                                input logic [15:0] d2, input logic [15:0] d3);
    @(negedge clock);
    bus.i_data0 = d0; bus.i_data1 = d1; bus.i_data2 = d2; bus.i_data3 = d3;
    bus.i_start = 1'b1;
    exp_q.push_back({d0, d1, d2, d3});
    @(negedge clock);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_frame();
    repeat (PERIOD + 4) @(negedge clock);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.i_start = 1'b0;
    bus.i_data0 = '0; bus.i_data1 = '0; bus.i_data2 = '0; bus.i_data3 = '0;
    lb.i_start = 1'b0;
    lb.i_data0 = '0; lb.i_data1 = '0; lb.i_data2 = '0; lb.i_data3 = '0;
    rst_n = 1'b0;

    repeat (2) @(negedge clock);
    check_output("reset_cs",   {63'd0, bus.o_SPI_CS},    64'd1);
    check_output("reset_sclk", {63'd0, bus.o_SPI_clock}, 64'd0);
    check_output("reset_data", {63'd0, bus.o_SPI_data},  64'd0);
    check_output("reset_busy", {63'd0, bus.o_busy},      64'd0);
    check_output("reset_done", {63'd0, bus.o_done},      64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clock);

    $display("[TB] directed frame");
    apply_stimulus(16'h1234, 16'hABCD, 16'h0000, 16'hFFFF);
    exp_done++;
    wait_frame();

    $display("[TB] starts and data changes while busy");
    apply_stimulus(16'h1234, 16'hABCD, 16'h0000, 16'hFFFF);
    exp_done++;
    repeat (9) @(negedge clock);
    bus.i_start = 1'b1;
    @(negedge clock);
    bus.i_start = 1'b0;
    check_output("busy_mid_frame", {63'd0, bus.o_busy}, 64'd1);
    bus.i_data0 = 16'h5555;
    repeat (489) @(negedge clock);
    bus.i_start = 1'b1;
    @(negedge clock);
    bus.i_start = 1'b0;
    wait_frame();

    $display("[TB] back-to-back frames with start held high");
    b2b = 1;
    @(negedge clock);
    bus.i_data0 = 16'hA5A5; bus.i_data1 = 16'h5A5A; bus.i_data2 = 16'hA5A5; bus.i_data3 = 16'h5A5A;
    bus.i_start = 1'b1;
    exp_q.push_back(64'hA5A5_5A5A_A5A5_5A5A);
    exp_done++;
    @(negedge clock);
    bus.i_data0 = 16'h5A5A; bus.i_data1 = 16'hA5A5; bus.i_data2 = 16'h5A5A; bus.i_data3 = 16'hA5A5;
    exp_q.push_back(64'h5A5A_A5A5_5A5A_A5A5);
    exp_done++;
    repeat (PERIOD) @(negedge clock);
    bus.i_data0 = 16'hA5A5; bus.i_data1 = 16'h5A5A; bus.i_data2 = 16'hA5A5; bus.i_data3 = 16'h5A5A;
    exp_q.push_back(64'hA5A5_5A5A_A5A5_5A5A);
    exp_done++;
    repeat (PERIOD) @(negedge clock);
    bus.i_start = 1'b0;
    wait_frame();
    b2b = 0;

    $display("[TB] reset in the middle of a frame");
    apply_stimulus(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    repeat (299) @(negedge clock);
    #2;
    abort_req++;
    rst_n = 1'b0;
    #1;
    check_output("abort_cs",   {63'd0, bus.o_SPI_CS},    64'd1);
    check_output("abort_sclk", {63'd0, bus.o_SPI_clock}, 64'd0);
    check_output("abort_data", {63'd0, bus.o_SPI_data},  64'd0);
    check_output("abort_busy", {63'd0, bus.o_busy},      64'd0);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    repeat (3) @(negedge clock);

    $display("[TB] randomized frames");
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      exp_done++;
      wait_frame();
      repeat ($urandom_range(0, 20)) @(negedge clock);
    end

    $display("[TB] minimum-timing loopback into deglitching receiver");
    @(negedge clock);
    lb.i_data0 = 16'h0001; lb.i_data1 = 16'h8000; lb.i_data2 = 16'h7FFF; lb.i_data3 = 16'hC3C3;
    lb.i_start = 1'b1;
    @(negedge clock);
    lb.i_start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (lb_flag) break;
    end
    check_output("loopback_received", {63'd0, lb_flag}, 64'd1);
    check_output("loopback_word0", lb_words[63:48], 16'h0001);
    check_output("loopback_word1", lb_words[47:32], 16'h8000);
    check_output("loopback_word2", lb_words[31:16], 16'h7FFF);
    check_output("loopback_word3", lb_words[15:0],  16'hC3C3);

    repeat (10) @(negedge clock);
    check_output("done_count", done_count, exp_done);
    check_output("frames_outstanding", exp_q.size(), 0);
    check_output("sclk_rise_while_cs_high", glitches, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
